// File: rtl/rom_fetch_sequencer_if.sv
// Issue/ROM/redirect bundle between the fetch sequencer (master) and its ROM + datapath (slave).
// Signal names keep the datapath's established i/o naming as seen from the sequencer.
interface rom_fetch_sequencer_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 28
);
   logic [ADDR_W-1:0]  oRomAddress;
   logic [INSTR_W-1:0] iRomInstruction;
   logic [INSTR_W-1:0] oInstruction;
   logic               oInstrValid;
   logic [ADDR_W-1:0]  oPC;
   logic               iReady;
   logic               iBranchTaken;
   logic [ADDR_W-1:0]  iBranchTarget;
   logic               iHalt;
   logic               oDelayActive;

   modport master (
      output oRomAddress, oInstruction, oInstrValid, oPC, oDelayActive,
      input  iRomInstruction, iReady, iBranchTaken, iBranchTarget, iHalt
   );

   modport slave (
      input  oRomAddress, oInstruction, oInstrValid, oPC, oDelayActive,
      output iRomInstruction, iReady, iBranchTaken, iBranchTarget, iHalt
   );
endinterface

// File: rtl/rom_fetch_sequencer.sv
// Instruction fetch: owns PC, runs NOP delays and JMPs locally, issues others one cycle after fetch.
// Holds PC and issue register while the issue slot is occupied; redirects kill the pending instruction.
module rom_fetch_sequencer #(
   parameter int         ADDR_W  = 16,
   parameter int         INSTR_W = 28,
   parameter logic [3:0] NOP_OP  = 4'd0,
   parameter logic [3:0] JMP_OP  = 4'd13
) (
   input  logic                  iClock,
   input  logic                  iReset_n,
   rom_fetch_sequencer_if.master bus
);
   typedef enum logic [1:0] {S_FETCH, S_DELAY, S_HALT} state_t;

   state_t             r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_opc;
   logic [INSTR_W-1:0] r_instr;
   logic               r_vld;
   logic               r_delay;
   logic [23:0]        r_cnt;

   logic               w_xfer;
   logic               w_slot_free;
   logic [3:0]         w_op;
   logic [23:0]        w_imm;
   logic [ADDR_W-1:0]  w_jmp_tgt;
   logic [ADDR_W-1:0]  w_pc_inc;

   assign w_xfer      = r_vld & bus.iReady;
   assign w_slot_free = ~r_vld | bus.iReady;
   assign w_op        = bus.iRomInstruction[INSTR_W-1 -: 4];
   assign w_imm       = bus.iRomInstruction[23:0];
   assign w_jmp_tgt   = {{(ADDR_W-8){1'b0}}, bus.iRomInstruction[23:16]};
   assign w_pc_inc    = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

   assign bus.oRomAddress  = r_pc;
   assign bus.oInstruction = r_instr;
   assign bus.oInstrValid  = r_vld;
   assign bus.oPC          = r_opc;
   assign bus.oDelayActive = r_delay;

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         r_state <= S_FETCH;
         r_pc    <= '0;
         r_opc   <= '0;
         r_instr <= '0;
         r_vld   <= 1'b0;
         r_delay <= 1'b0;
         r_cnt   <= '0;
      end else if (bus.iBranchTaken) begin
         // Redirect wins even over a transfer: the pending instruction is on the wrong path.
         r_pc    <= bus.iBranchTarget;
         r_vld   <= 1'b0;
         r_cnt   <= '0;
         r_delay <= 1'b0;
         r_state <= bus.iHalt ? S_HALT : S_FETCH;
      end else if (bus.iHalt) begin
         r_state <= S_HALT;
         r_cnt   <= '0;
         r_delay <= 1'b0;
         if (w_xfer) r_vld <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_slot_free) begin
                  r_vld <= 1'b0;
                  if (w_op == NOP_OP) begin
                     r_pc <= w_pc_inc;
                     if (w_imm != '0) begin
                        r_cnt   <= w_imm;
                        r_state <= S_DELAY;
                        r_delay <= 1'b1;
                     end
                  end else if (w_op == JMP_OP) begin
                     r_pc <= w_jmp_tgt;
                  end else begin
                     r_instr <= bus.iRomInstruction;
                     r_opc   <= r_pc;
                     r_vld   <= 1'b1;
                     r_pc    <= w_pc_inc;
                  end
               end
            end
            S_DELAY: begin
               if (w_xfer) r_vld <= 1'b0;
               r_cnt <= r_cnt - 24'd1;
               if (r_cnt <= 24'd1) begin
                  r_state <= S_FETCH;
                  r_delay <= 1'b0;
               end
            end
            S_HALT: begin
               if (w_xfer) r_vld <= 1'b0;
               r_state <= S_FETCH;
            end
            default: begin
               r_state <= S_FETCH;
               r_delay <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Bench for rom_fetch_sequencer: behavioural ROM plus an issue-order scoreboard of (oPC, instruction).
module tb_rom_fetch_sequencer;
   logic iClock   = 1'b0;
   logic iReset_n = 1'b0;

   rom_fetch_sequencer_if #(.ADDR_W(16), .INSTR_W(28)) bus ();

   rom_fetch_sequencer dut (
      .iClock   (iClock),
      .iReset_n (iReset_n),
      .bus      (bus.master)
   );

   always #5 iClock = ~iClock;

   logic [27:0] rom [0:65535];
   assign bus.iRomInstruction = rom[bus.oRomAddress];

   typedef struct packed {
      logic [15:0] pc;
      logic [27:0] instr;
   } xfer_t;

   xfer_t exp_q[$];
   bit    sb_en = 1'b0;
   int    n_checks = 0;
   int    n_fail   = 0;

   // Inputs are already driven for the coming edge; a transfer there is scored against the queue.
   task automatic tick();
      xfer_t e;
      if (sb_en && iReset_n && bus.oInstrValid && bus.iReady && !bus.iBranchTaken) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra got pc=%h instr=%h want no transfer", bus.oPC, bus.oInstruction);
         end else begin
            e = exp_q.pop_front();
            if (bus.oPC !== e.pc || bus.oInstruction !== e.instr) begin
               n_fail++;
               $display("FAIL sb_xfer got pc=%h instr=%h want pc=%h instr=%h",
                        bus.oPC, bus.oInstruction, e.pc, e.instr);
            end
         end
      end
      @(negedge iClock);
   endtask

   // Leaves reset released at a falling edge; the next rising edge is edge 0.
   task automatic do_reset();
      iReset_n          = 1'b0;
      bus.iReady        = 1'b0;
      bus.iBranchTaken  = 1'b0;
      bus.iBranchTarget = '0;
      bus.iHalt         = 1'b0;
      sb_en             = 1'b0;
      exp_q.delete();
      for (int a = 0; a < 65536; a++) rom[a] = {4'h5, a[7:0], a[15:0]};
      @(negedge iClock);
      @(negedge iClock);
      iReset_n = 1'b1;
   endtask

   task automatic test_reset();
      iReset_n = 1'b0;
      #3;
      n_checks++;
      if ({bus.oRomAddress, bus.oInstruction, bus.oInstrValid, bus.oPC, bus.oDelayActive} !== '0) begin
         n_fail++;
         $display("FAIL reset_vals got addr=%h instr=%h vld=%b pc=%h dly=%b want all zero",
                  bus.oRomAddress, bus.oInstruction, bus.oInstrValid, bus.oPC, bus.oDelayActive);
      end
   endtask

   task automatic test_stream();
      do_reset();
      bus.iReady = 1'b1;
      sb_en = 1'b1;
      for (int k = 0; k < 4; k++) exp_q.push_back({k[15:0], rom[k]});
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if ({bus.oInstrValid, bus.oPC, bus.oInstruction} !== {1'b1, k[15:0], rom[k]}) begin
            n_fail++;
            $display("FAIL stream_%0d got vld=%b pc=%h instr=%h want vld=1 pc=%h instr=%h",
                     k, bus.oInstrValid, bus.oPC, bus.oInstruction, k[15:0], rom[k]);
         end
      end
      tick();
      sb_en = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL stream_sb_left got %0d want 0", exp_q.size());
      end
   endtask

   task automatic test_nop();
      int delays;
      int first;
      logic [15:0] first_pc;
      do_reset();
      rom[0] = {4'd0, 24'd3};
      bus.iReady = 1'b1;
      sb_en = 1'b1;
      exp_q.push_back({16'd1, rom[1]});
      exp_q.push_back({16'd2, rom[2]});
      delays = 0;
      first = -1;
      first_pc = '0;
      for (int s = 0; s < 7; s++) begin
         tick();
         if (bus.oDelayActive) delays++;
         if (bus.oInstrValid && first < 0) begin
            first = s;
            first_pc = bus.oPC;
         end
      end
      sb_en = 1'b0;
      n_checks++;
      if (delays != 3) begin
         n_fail++;
         $display("FAIL nop_delay_cycles got %0d want 3", delays);
      end
      n_checks++;
      if (first != 4 || first_pc !== 16'd1) begin
         n_fail++;
         $display("FAIL nop_first_valid got cycle=%0d pc=%h want cycle=4 pc=0001", first, first_pc);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL nop_sb_left got %0d want 0", exp_q.size());
      end
   endtask

   task automatic test_jmp();
      do_reset();
      rom[16] = {4'd13, 8'd2, 16'd0};
      bus.iReady = 1'b1;
      for (int s = 0; s < 18; s++) begin
         tick();
         if (s == 15) begin
            n_checks++;
            if ({bus.oInstrValid, bus.oPC} !== {1'b1, 16'd15}) begin
               n_fail++;
               $display("FAIL jmp_before got vld=%b pc=%h want vld=1 pc=000f", bus.oInstrValid, bus.oPC);
            end
         end else if (s == 16) begin
            n_checks++;
            if ({bus.oInstrValid, bus.oRomAddress} !== {1'b0, 16'd2}) begin
               n_fail++;
               $display("FAIL jmp_bubble got vld=%b addr=%h want vld=0 addr=0002",
                        bus.oInstrValid, bus.oRomAddress);
            end
         end else if (s == 17) begin
            n_checks++;
            if ({bus.oInstrValid, bus.oPC} !== {1'b1, 16'd2}) begin
               n_fail++;
               $display("FAIL jmp_target got vld=%b pc=%h want vld=1 pc=0002", bus.oInstrValid, bus.oPC);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.iReady = 1'b1;
      for (int s = 0; s < 6; s++) tick();
      sb_en = 1'b1;
      exp_q.push_back({16'd5, rom[5]});
      exp_q.push_back({16'd6, rom[6]});
      bus.iReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if ({bus.oInstrValid, bus.oPC, bus.oInstruction, bus.oRomAddress} !==
             {1'b1, 16'd5, rom[5], 16'd6}) begin
            n_fail++;
            $display("FAIL bp_hold_%0d got vld=%b pc=%h instr=%h addr=%h want vld=1 pc=0005 instr=%h addr=0006",
                     i, bus.oInstrValid, bus.oPC, bus.oInstruction, bus.oRomAddress, rom[5]);
         end
      end
      bus.iReady = 1'b1;
      tick();
      n_checks++;
      if ({bus.oInstrValid, bus.oPC} !== {1'b1, 16'd6}) begin
         n_fail++;
         $display("FAIL bp_release got vld=%b pc=%h want vld=1 pc=0006", bus.oInstrValid, bus.oPC);
      end
      tick();
      sb_en = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bp_sb_left got %0d want 0", exp_q.size());
      end
   endtask

   task automatic test_branch();
      do_reset();
      bus.iReady = 1'b1;
      for (int s = 0; s < 5; s++) tick();
      sb_en = 1'b1;
      exp_q.push_back({16'd8, rom[8]});
      bus.iBranchTaken  = 1'b1;
      bus.iBranchTarget = 16'd8;
      tick();
      bus.iBranchTaken = 1'b0;
      n_checks++;
      if ({bus.oInstrValid, bus.oRomAddress} !== {1'b0, 16'd8}) begin
         n_fail++;
         $display("FAIL br_kill got vld=%b addr=%h want vld=0 addr=0008", bus.oInstrValid, bus.oRomAddress);
      end
      tick();
      n_checks++;
      if ({bus.oInstrValid, bus.oPC} !== {1'b1, 16'd8}) begin
         n_fail++;
         $display("FAIL br_target got vld=%b pc=%h want vld=1 pc=0008", bus.oInstrValid, bus.oPC);
      end
      tick();
      sb_en = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL br_sb_left got %0d want 0", exp_q.size());
      end

      do_reset();
      rom[0] = {4'd0, 24'd10};
      bus.iReady = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus.oDelayActive !== 1'b1) begin
         n_fail++;
         $display("FAIL br_dly_pre got dly=%b want 1", bus.oDelayActive);
      end
      bus.iBranchTaken  = 1'b1;
      bus.iBranchTarget = 16'd8;
      tick();
      bus.iBranchTaken = 1'b0;
      n_checks++;
      if ({bus.oDelayActive, bus.oInstrValid, bus.oRomAddress} !== {1'b0, 1'b0, 16'd8}) begin
         n_fail++;
         $display("FAIL br_dly_abort got dly=%b vld=%b addr=%h want dly=0 vld=0 addr=0008",
                  bus.oDelayActive, bus.oInstrValid, bus.oRomAddress);
      end
      tick();
      n_checks++;
      if ({bus.oInstrValid, bus.oPC} !== {1'b1, 16'd8}) begin
         n_fail++;
         $display("FAIL br_dly_target got vld=%b pc=%h want vld=1 pc=0008", bus.oInstrValid, bus.oPC);
      end
   endtask

   task automatic test_halt_reset();
      do_reset();
      rom[3] = {4'd0, 24'd20};
      bus.iReady = 1'b1;
      for (int s = 0; s < 4; s++) tick();
      n_checks++;
      if ({bus.oDelayActive, bus.oRomAddress} !== {1'b1, 16'd4}) begin
         n_fail++;
         $display("FAIL halt_dly_pre got dly=%b addr=%h want dly=1 addr=0004", bus.oDelayActive, bus.oRomAddress);
      end
      bus.iHalt = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if ({bus.oDelayActive, bus.oInstrValid, bus.oRomAddress} !== {1'b0, 1'b0, 16'd4}) begin
            n_fail++;
            $display("FAIL halt_in_dly_%0d got dly=%b vld=%b addr=%h want dly=0 vld=0 addr=0004",
                     i, bus.oDelayActive, bus.oInstrValid, bus.oRomAddress);
         end
      end
      bus.iHalt = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({bus.oInstrValid, bus.oPC} !== {1'b1, 16'd4}) begin
         n_fail++;
         $display("FAIL halt_resume got vld=%b pc=%h want vld=1 pc=0004", bus.oInstrValid, bus.oPC);
      end
      bus.iReady = 1'b0;
      bus.iHalt  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if ({bus.oInstrValid, bus.oPC, bus.oInstruction, bus.oRomAddress} !==
             {1'b1, 16'd4, rom[4], 16'd5}) begin
            n_fail++;
            $display("FAIL halt_pending_%0d got vld=%b pc=%h instr=%h addr=%h want vld=1 pc=0004 addr=0005",
                     i, bus.oInstrValid, bus.oPC, bus.oInstruction, bus.oRomAddress);
         end
      end
      #2 iReset_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.oRomAddress, bus.oInstruction, bus.oInstrValid, bus.oPC, bus.oDelayActive} !== '0) begin
         n_fail++;
         $display("FAIL halt_async_rst got addr=%h instr=%h vld=%b pc=%h dly=%b want all zero",
                  bus.oRomAddress, bus.oInstruction, bus.oInstrValid, bus.oPC, bus.oDelayActive);
      end
      @(negedge iClock);
      iReset_n   = 1'b1;
      bus.iHalt  = 1'b0;
      bus.iReady = 1'b1;
      tick();
      n_checks++;
      if ({bus.oInstrValid, bus.oPC, bus.oInstruction} !== {1'b1, 16'd0, rom[0]}) begin
         n_fail++;
         $display("FAIL halt_restart got vld=%b pc=%h instr=%h want vld=1 pc=0000 instr=%h",
                  bus.oInstrValid, bus.oPC, bus.oInstruction, rom[0]);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      bus.iReady        = 1'b1;
      bus.iBranchTaken  = 1'b1;
      bus.iBranchTarget = 16'hFFFF;
      tick();
      bus.iBranchTaken = 1'b0;
      n_checks++;
      if (bus.oRomAddress !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL wrap_pre got addr=%h want ffff", bus.oRomAddress);
      end
      tick();
      n_checks++;
      if ({bus.oInstrValid, bus.oPC, bus.oInstruction, bus.oRomAddress} !==
          {1'b1, 16'hFFFF, rom[16'hFFFF], 16'h0000}) begin
         n_fail++;
         $display("FAIL wrap_issue got vld=%b pc=%h instr=%h addr=%h want vld=1 pc=ffff addr=0000",
                  bus.oInstrValid, bus.oPC, bus.oInstruction, bus.oRomAddress);
      end
      tick();
      n_checks++;
      if ({bus.oInstrValid, bus.oPC} !== {1'b1, 16'h0000}) begin
         n_fail++;
         $display("FAIL wrap_next got vld=%b pc=%h want vld=1 pc=0000", bus.oInstrValid, bus.oPC);
      end
   endtask

   initial begin
      bus.iReady        = 1'b0;
      bus.iBranchTaken  = 1'b0;
      bus.iBranchTarget = '0;
      bus.iHalt         = 1'b0;
      for (int a = 0; a < 65536; a++) rom[a] = {4'h5, a[7:0], a[15:0]};
      test_reset();
      test_stream();
      test_nop();
      test_jmp();
      test_backpressure();
      test_branch();
      test_halt_reset();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rom_fetch_sequencer.md
# rom_fetch_sequencer

Instruction-fetch controller between the program ROM and the execute datapath. Owns the program counter and drives the ROM address. Registers each fetched 28-bit instruction onto a valid/ready issue port. Executes `NOP` (timed delay) and `JMP` (absolute jump) locally. Applies branch redirects reported back by the datapath, and supports halt.

## Interface
- `ADDR_W`, 16, PC and ROM address width.
- `INSTR_W`, 28, instruction width; opcode is `[INSTR_W-1:INSTR_W-4]`.
- `NOP_OP`, 4'd0, opcode executed as a delay; 24-bit immediate `[23:0]` is the wait count.
- `JMP_OP`, 4'd13, opcode executed as a jump; target is `{8'b0, instr[23:16]}`.
- `iClock` in 1: single clock, rising edge.
- `iReset_n` in 1: asynchronous, active-low reset.
- `oRomAddress` out ADDR_W: ROM address, always equal to the internal PC register.
- `iRomInstruction` in INSTR_W: combinational ROM data for `oRomAddress`.
- `oInstruction` out INSTR_W: issued instruction register.
- `oInstrValid` out 1: `oInstruction` holds an unconsumed instruction.
- `oPC` out ADDR_W: ROM address `oInstruction` was fetched from.
- `iReady` in 1: datapath accepts the instruction this cycle.
- `iBranchTaken` in 1: datapath redirect strobe, one cycle.
- `iBranchTarget` in ADDR_W: redirect address.
- `iHalt` in 1: level; suspends fetching.
- `oDelayActive` out 1: high while in DELAY.

## Operation
- States: FETCH, DELAY, HALT.
- Reset values: PC=0, state=FETCH, `oInstruction`=0, `oInstrValid`=0, `oPC`=0, delay counter=0, `oDelayActive`=0.
- A transfer occurs when `oInstrValid & iReady`.
- The issue slot is free when `!oInstrValid | iReady`.
- FETCH, slot free, no redirect, no halt. Decode `iRomInstruction[27:24]`:
  - `NOP_OP`: nothing issued (`oInstrValid` <= 0 if the slot was consumed).
    - PC <= PC+1.
    - If imm != 0: counter <= imm, go DELAY.
  - `JMP_OP`: nothing issued; PC <= jump target.
  - Any other opcode: `oInstruction` <= ROM data, `oPC` <= PC, `oInstrValid` <= 1, PC <= PC+1.
- FETCH, slot not free: PC, `oInstruction` and `oPC` hold.
- DELAY:
  - Counter decrements each cycle. When the counter is 1, the next state is FETCH.
  - No ROM fetch occurs. A pending issued instruction still completes its handshake.
- HALT: entered whenever `iHalt`=1, from any state.
  - DELAY progress is abandoned; the counter is cleared and PC is already advanced.
  - The pending instruction stays visible and may still transfer.
  - Returns to FETCH on the first cycle `iHalt`=0.
- Priority per cycle: reset > `iBranchTaken` > `iHalt` > DELAY/FETCH action.
- Redirect (`iBranchTaken`=1):
  - PC <= `iBranchTarget`; `oInstrValid` <= 0 (pending instruction killed, even if `iReady`=1 that cycle).
  - Counter cleared. Next state is HALT if `iHalt`=1, else FETCH.
  - The ROM data that cycle is discarded.
- PC arithmetic is modulo 2^ADDR_W: PC+1 at 16'hFFFF wraps to 0.
- A JMP to its own address loops forever, issuing nothing. This is legal.

## Timing
- Reset deasserted before edge 0: first fetch is at edge 0, with `oInstrValid`=1 and `oPC`=0 after edge 0.
- Throughput is one instruction per cycle with `iReady` held high.
- A non-control instruction at address A appears on `oInstruction` the edge after PC=A and the slot is free.
- NOP imm=n costs n+1 fetch-free cycles; n=0 gives one bubble.
- JMP costs one bubble cycle.
- Redirect: first instruction from the target is valid the edge after the redirect edge + 1.
- `oDelayActive` is registered and equals (state==DELAY).
- Async reset mid-DELAY or mid-handshake immediately forces all reset values; no transfer completes that cycle.

## Test plan
- Reset, ROM = four non-control instructions at 0..3, `iReady`=1.
  - Required: valid on four consecutive cycles with `oPC`=0,1,2,3 and matching `oInstruction`.
- NOP imm=3 at address 0, non-control instruction at 1.
  - Required: `oDelayActive` high for exactly 3 cycles; no valid for 4 cycles; then `oPC`=1.
- JMP target 2 at address 16, reached by sequential execution.
  - Required: one bubble after `oPC`=15, then `oPC`=2.
- Hold `iReady`=0 for 5 cycles with a valid instruction at `oPC`=5.
  - Required: `oInstruction`/`oPC` stable and `oRomAddress`=6 throughout.
  - Required: after `iReady`=1, next `oPC`=6.
- Pulse `iBranchTaken` with target 8 while the instruction at `oPC`=4 is pending and `iReady`=1; repeat during DELAY.
  - Required: pending instruction not consumed, delay aborted, next `oPC`=8.
- `iHalt` during DELAY, then `iReset_n` low mid-HALT.
  - Required: halted with pending instruction held.
  - Required: reset immediately zeroes all outputs; fetch restarts at `oPC`=0.
- PC=16'hFFFF non-control instruction.
  - Required: next `oRomAddress`=0.
